// File: rtl/depuncturer_pkg.sv
// depuncturer_pkg
//   Shared definitions for the Rx depuncturer: code-rate encodings, erasure
//   masks, the puncturing phase type, the output pair record and small helper
//   functions describing the 802.11a puncturing patterns.
//   No ports (package).
package depuncturer_pkg;

    // Code rate encodings as presented on the rate input
    localparam logic [1:0] RATE_1_2  = 2'd0;
    localparam logic [1:0] RATE_2_3  = 2'd1;
    localparam logic [1:0] RATE_3_4  = 2'd2;
    localparam logic [1:0] RATE_RSVD = 2'd3;

    // Erasure masks: bit 1 flags A erased, bit 0 flags B erased
    localparam logic [1:0] ERA_NONE = 2'b00;
    localparam logic [1:0] ERA_B    = 2'b01;
    localparam logic [1:0] ERA_A    = 2'b10;

    // Position inside the puncturing period
    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;

    // One mother-code pair as handed to the Viterbi decoder
    typedef struct packed {
        logic       a;
        logic       b;
        logic [1:0] era;
    } pair_t;

    // Number of received bits consumed to build the pair at this phase.
    // The reserved rate code behaves as rate 1/2.
    function automatic logic [1:0] pop_need(input logic [1:0] rate, input phase_t ph);
        logic [1:0] n;
        n = 2'd2;
        if ((rate == RATE_2_3) || (rate == RATE_3_4)) begin
            n = (ph == PH0) ? 2'd2 : 2'd1;
        end
        return n;
    endfunction

    // Phase following ph once a pair has been emitted
    function automatic phase_t next_phase(input logic [1:0] rate, input phase_t ph);
        phase_t nx;
        nx = PH0;
        case (rate)
            RATE_2_3: nx = (ph == PH0) ? PH1 : PH0;
            RATE_3_4: begin
                case (ph)
                    PH0:     nx = PH1;
                    PH1:     nx = PH2;
                    default: nx = PH0;
                endcase
            end
            default:  nx = PH0;
        endcase
        return nx;
    endfunction

    // Build the output pair from the two oldest buffered bits (b0 oldest).
    // PH1 carries A with B punctured, PH2 carries B with A punctured.
    function automatic pair_t build_pair(input phase_t ph, input logic b0, input logic b1);
        pair_t p;
        case (ph)
            PH1:     p = '{a: b0,   b: 1'b0, era: ERA_B};
            PH2:     p = '{a: 1'b0, b: b0,   era: ERA_A};
            default: p = '{a: b0,   b: b1,   era: ERA_NONE};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/depuncturer_bit_fifo2.sv
// bit_fifo2
//   Bit-granular circular buffer: accepts 2 bits per push and releases 0, 1 or
//   2 bits per pop. The two oldest bits are always visible on b0_o/b1_o.
//   Ports:
//     clk, rst       clock, asynchronous active-low reset
//     flush_i        empty the buffer and return both pointers to 0; a push in
//                    the same cycle lands at the start of the emptied buffer
//     push_i         store push_bits_i (caller guarantees at least 2 free slots)
//     push_bits_i    [1] written first (older), [0] second
//     pop_n_i        number of bits to release this cycle (0..2, <= count)
//     b0_o, b1_o     oldest and second-oldest buffered bit
//     count_o        bits currently held
//     free_o         DEPTH - count_o
module bit_fifo2
    import depuncturer_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [1:0]    push_bits_i,
    input  logic [1:0]    pop_n_i,
    output logic          b0_o,
    output logic          b1_o,
    output logic [AW:0]   count_o,
    output logic [AW:0]   free_o
);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    wr_base, wr_next, rd_base, rd_next;
    logic [AW:0]      count_base;

    always_comb begin
        // A flush rebases the write so that simultaneous input becomes the
        // first bits of the new packet; any pop request is discarded.
        wr_base    = flush_i ? '0 : wr_ptr_q;
        rd_base    = flush_i ? '0 : rd_ptr_q;
        count_base = flush_i ? '0 : (count_q - (AW+1)'(pop_n_i));
        // Pointer arithmetic is modulo DEPTH, so a 2-bit write may straddle
        // the end of the buffer.
        wr_next    = wr_base + AW'(1);
        rd_ptr_d   = flush_i ? '0 : (rd_base + AW'(pop_n_i));
        wr_ptr_d   = push_i ? (wr_base + AW'(2)) : wr_base;
        count_d    = push_i ? (count_base + (AW+1)'(2)) : count_base;
        rd_next    = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_base] <= push_bits_i[1];
            mem_q[wr_next] <= push_bits_i[0];
        end
    end

    assign b0_o    = mem_q[rd_ptr_q];
    assign b1_o    = mem_q[rd_next];
    assign count_o = count_q;
    assign free_o  = (AW+1)'(DEPTH) - count_q;

endmodule

// File: rtl/depuncturer.sv
// depuncturer
//   Restores the rate-1/2 mother-code pair stream (A,B) from the punctured
//   hard-decision stream leaving the de-interleaver, inserting erasures at
//   punctured positions for rates 2/3 and 3/4. A bit buffer absorbs the
//   mismatch between the bursty 2-bit input and the one-pair-per-cycle output.
//   Ports:
//     clk, rst     clock, asynchronous active-low reset
//     start        packet start pulse: flush buffer, phase to 0, latch rate
//     rate         0=1/2, 1=2/3, 2=3/4, 3=reserved (behaves as 1/2)
//     in_valid     in_bits valid; input cannot be stalled
//     in_bits      [1] earlier in time than [0]
//     out_ready    decoder accepts the current pair
//     out_valid    out_a/out_b/out_era hold a pair
//     out_a/out_b  coded bits (0 when erased)
//     out_era      [1]=A erased, [0]=B erased
//     overflow     sticky: input arrived with fewer than 2 free slots
module depuncturer
    import depuncturer_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] rate,
    input  logic       in_valid,
    input  logic [1:0] in_bits,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       out_a,
    output logic       out_b,
    output logic [1:0] out_era,
    output logic       overflow
);

    phase_t      phase_q;
    logic [1:0]  rate_q;
    logic        vld_q;
    pair_t       pair_q;
    logic        ovf_q;

    logic        b0, b1;
    logic [AW:0] count, free;
    logic        room;
    logic        push_ok;
    logic [1:0]  need;
    logic        fire;
    logic [1:0]  pop_n;

    // Free space is judged on the pre-push, pre-pop occupancy; a start
    // empties the buffer, so input on that cycle always fits.
    assign room    = (free >= (AW+1)'(2));
    assign push_ok = in_valid & (start | room);

    // A pair is produced only from bits already buffered before this cycle,
    // and only when the output register is empty or being drained.
    assign need  = pop_need(rate_q, phase_q);
    assign fire  = ~start & (count >= (AW+1)'(need)) & (~vld_q | out_ready);
    assign pop_n = fire ? need : 2'd0;

    bit_fifo2 #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (start),
        .push_i      (push_ok),
        .push_bits_i (in_bits),
        .pop_n_i     (pop_n),
        .b0_o        (b0),
        .b1_o        (b1),
        .count_o     (count),
        .free_o      (free)
    );

    // Phase FSM, output register and overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= PH0;
            rate_q  <= RATE_1_2;
            vld_q   <= 1'b0;
            pair_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (start) begin
            phase_q <= PH0;
            rate_q  <= rate;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (in_valid && !room) begin
                ovf_q <= 1'b1;
            end
            if (fire) begin
                pair_q  <= build_pair(phase_q, b0, b1);
                vld_q   <= 1'b1;
                phase_q <= next_phase(rate_q, phase_q);
            end else if (out_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign out_valid = vld_q;
    assign out_a     = pair_q.a;
    assign out_b     = pair_q.b;
    assign out_era   = pair_q.era;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_depuncturer.sv
// tb_depuncturer
//   Bench for the depuncturer: a 512-bit instance for the functional scenarios
//   and an 8-bit instance (same stimulus) for the overflow scenario. Expected
//   pairs come from a queue model that applies the puncturing patterns to the
//   accepted input bit stream.
module tb_depuncturer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] rate = 2'd0;
    logic       in_valid = 1'b0;
    logic [1:0] in_bits = 2'd0;
    logic       out_ready = 1'b0;

    logic       out_valid, out_a, out_b, overflow;
    logic [1:0] out_era;
    logic       out_valid8, out_a8, out_b8, overflow8;
    logic [1:0] out_era8;

    int total = 0;
    int bad = 0;

    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    logic [3:0] got8_q[$];
    bit         mbits[$];
    int         mph = 0;
    int         mrate = 0;
    int         cyc = 0;
    int         first_vld = -1;

    always #5 clk = ~clk;

    depuncturer #(.DEPTH(512), .AW(9)) dut (
        .clk(clk), .rst(rst), .start(start), .rate(rate), .in_valid(in_valid),
        .in_bits(in_bits), .out_ready(out_ready), .out_valid(out_valid),
        .out_a(out_a), .out_b(out_b), .out_era(out_era), .overflow(overflow)
    );

    depuncturer #(.DEPTH(8), .AW(3)) dut8 (
        .clk(clk), .rst(rst), .start(start), .rate(rate), .in_valid(in_valid),
        .in_bits(in_bits), .out_ready(out_ready), .out_valid(out_valid8),
        .out_a(out_a8), .out_b(out_b8), .out_era(out_era8), .overflow(overflow8)
    );

    // Reference: consume the accepted bit stream period by period.
    // Rate 1/2: every pair takes 2 bits. Rate 2/3: {2 bits, 1 bit + B erased}.
    // Rate 3/4: {2 bits, 1 bit + B erased, 1 bit + A erased}.
    function automatic void model_gen();
        int need;
        int period;
        forever begin
            need   = (mrate != 0 && mph != 0) ? 1 : 2;
            period = (mrate == 1) ? 2 : ((mrate == 2) ? 3 : 1);
            if (mbits.size() < need) break;
            case (mph)
                0:       exp_q.push_back({mbits[0], mbits[1], 2'b00});
                1:       exp_q.push_back({mbits[0], 1'b0, 2'b01});
                default: exp_q.push_back({1'b0, mbits[0], 2'b10});
            endcase
            for (int k = 0; k < need; k++) void'(mbits.pop_front());
            mph = (mph + 1) % period;
        end
    endfunction

    // One clock: drive inputs, record the handshake completing at the coming
    // edge, update the model, then advance to 1 time unit past the edge.
    task automatic tick(input bit st, input bit [1:0] r, input bit iv,
                        input bit [1:0] bits, input bit rdy);
        start = st; rate = r; in_valid = iv; in_bits = bits; out_ready = rdy;
        if (out_valid && rdy) got_q.push_back({out_a, out_b, out_era});
        if (out_valid8 && rdy) got8_q.push_back({out_a8, out_b8, out_era8});
        if (out_valid && first_vld < 0) first_vld = cyc;
        if (st) begin
            got_q.delete(); got8_q.delete(); exp_q.delete(); mbits.delete();
            mph = 0;
            mrate = (r == 2'd3) ? 0 : int'(r);
        end
        if (iv) begin
            mbits.push_back(bits[1]);
            mbits.push_back(bits[0]);
            model_gen();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Let the output drain with out_ready high; timed_out set if the
    // expected pairs did not all arrive within the budget.
    task automatic drain(input int budget, output bit timed_out);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
            n++;
        end
        timed_out = (got_q.size() < exp_q.size());
        for (int k = 0; k < 4; k++) tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({out_valid, out_a, out_b, out_era, overflow} !== 6'b0) begin
            bad++;
            $display("FAIL reset_async: got %b want 000000", {out_valid, out_a, out_b, out_era, overflow});
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, out_a, out_b, out_era, overflow} !== 6'b0) begin
            bad++;
            $display("FAIL reset_held: got %b want 000000", {out_valid, out_a, out_b, out_era, overflow});
        end
        total++;
        if ({out_valid8, out_a8, out_b8, out_era8, overflow8} !== 6'b0) begin
            bad++;
            $display("FAIL reset_dut8: got %b want 000000", {out_valid8, out_a8, out_b8, out_era8, overflow8});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rate12();
        logic [3:0] want[3];
        bit to;
        want[0] = 4'b1000; want[1] = 4'b0100; want[2] = 4'b1100;
        tick(1'b1, 2'd0, 1'b0, 2'd0, 1'b1);
        cyc = 0;
        first_vld = -1;
        tick(1'b0, 2'd0, 1'b1, 2'b10, 1'b1);
        tick(1'b0, 2'd0, 1'b1, 2'b01, 1'b1);
        tick(1'b0, 2'd0, 1'b1, 2'b11, 1'b1);
        drain(20, to);
        total++;
        if (first_vld != 2) begin
            bad++;
            $display("FAIL r12_latency: first out_valid at cycle %0d want 2", first_vld);
        end
        total++;
        if (got_q.size() != 3 || to) begin
            bad++;
            $display("FAIL r12_count: got %0d pairs want 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== want[i]) begin
                bad++;
                $display("FAIL r12_pair%0d: got %b want %b", i, got_q[i], want[i]);
            end
        end
    endtask

    task automatic test_rate23();
        logic [3:0] want[5];
        bit to;
        want[0] = 4'b1000; want[1] = 4'b1001; want[2] = 4'b1100;
        want[3] = 4'b0001; want[4] = 4'b0100;
        tick(1'b1, 2'd1, 1'b0, 2'd0, 1'b1);
        tick(1'b0, 2'd0, 1'b1, 2'b10, 1'b1);
        tick(1'b0, 2'd0, 1'b1, 2'b11, 1'b1);
        tick(1'b0, 2'd0, 1'b1, 2'b10, 1'b1);
        tick(1'b0, 2'd0, 1'b1, 2'b01, 1'b1);
        drain(30, to);
        total++;
        if (got_q.size() != 5 || to) begin
            bad++;
            $display("FAIL r23_count: got %0d pairs want 5", got_q.size());
        end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== want[i]) begin
                bad++;
                $display("FAIL r23_pair%0d: got %b want %b", i, got_q[i], want[i]);
            end
        end
    endtask

    task automatic test_rate34();
        logic [3:0] want[4];
        bit to;
        want[0] = 4'b1100; want[1] = 4'b0001; want[2] = 4'b0110; want[3] = 4'b1000;
        tick(1'b1, 2'd2, 1'b0, 2'd0, 1'b1);
        tick(1'b0, 2'd0, 1'b1, 2'b11, $urandom_range(0, 1));
        tick(1'b0, 2'd0, 1'b1, 2'b01, $urandom_range(0, 1));
        tick(1'b0, 2'd0, 1'b1, 2'b10, $urandom_range(0, 1));
        drain(30, to);
        total++;
        if (got_q.size() != 4 || to) begin
            bad++;
            $display("FAIL r34_count: got %0d pairs want 4", got_q.size());
        end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== want[i]) begin
                bad++;
                $display("FAIL r34_pair%0d: got %b want %b", i, got_q[i], want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int errs;
        tick(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 2'd0, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
            if (i >= 2) begin
                total++;
                if (out_valid !== 1'b1 || {out_a, out_b, out_era} !== exp_q[0]) begin
                    bad++;
                    $display("FAIL bp_hold%0d: got v=%b %b want v=1 %b", i, out_valid, {out_a, out_b, out_era}, exp_q[0]);
                end
            end
        end
        drain(100, to);
        total++;
        if (got_q.size() != exp_q.size() || to || exp_q.size() != 20) begin
            bad++;
            $display("FAIL bp_count: got %0d pairs want %0d (20)", got_q.size(), exp_q.size());
        end
        errs = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bp_order: %0d pairs differ from model, want 0", errs);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] sb[6];
        logic [3:0] want[5];
        tick(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            sb[k] = 2'($urandom_range(0, 3));
            tick(1'b0, 2'd0, 1'b1, sb[k], 1'b0);
            total++;
            if (overflow8 !== (k == 5)) begin
                bad++;
                $display("FAIL ovf_cycle%0d: got %b want %b", k, overflow8, (k == 5));
            end
        end
        for (int k = 0; k < 5; k++) want[k] = {sb[k], 2'b00};
        for (int k = 0; k < 12; k++) tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        total++;
        if (got8_q.size() != 5) begin
            bad++;
            $display("FAIL ovf_kept: got %0d pairs want 5", got8_q.size());
        end
        for (int k = 0; k < 5 && k < got8_q.size(); k++) begin
            total++;
            if (got8_q[k] !== want[k]) begin
                bad++;
                $display("FAIL ovf_pair%0d: got %b want %b", k, got8_q[k], want[k]);
            end
        end
        total++;
        if (overflow8 !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: got %b want 1", overflow8);
        end
        tick(1'b1, 2'd0, 1'b0, 2'd0, 1'b1);
        total++;
        if (overflow8 !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got %b want 0", overflow8);
        end
    endtask

    task automatic test_start_mid();
        bit to;
        tick(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 2'd0, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
        tick(1'b1, 2'd1, 1'b1, 2'b01, 1'b0);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_vld: got %b want 0", out_valid);
        end
        tick(1'b0, 2'd0, 1'b1, 2'b10, 1'b1);
        drain(20, to);
        total++;
        if (got_q.size() != 2 || to) begin
            bad++;
            $display("FAIL start_count: got %0d pairs want 2", got_q.size());
        end
        total++;
        if (got_q.size() < 2 || got_q[0] !== 4'b0100 || got_q[1] !== 4'b1001) begin
            bad++;
            $display("FAIL start_pairs: got %0d pairs first %b want 0100 1001", got_q.size(), (got_q.size() > 0) ? got_q[0] : 4'bx);
        end
    endtask

    task automatic test_rst_mid();
        bit to;
        tick(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 2'd0, 1'b1, 2'($urandom_range(0, 3)), 1'b0);
        in_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({out_valid, out_a, out_b, out_era, overflow} !== 6'b0) begin
            bad++;
            $display("FAIL rst_async: got %b want 000000", {out_valid, out_a, out_b, out_era, overflow});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(1'b1, 2'd0, 1'b1, 2'b11, 1'b1);
        tick(1'b0, 2'd0, 1'b1, 2'b00, 1'b1);
        drain(20, to);
        total++;
        if (got_q.size() != 2 || to || got_q[0] !== 4'b1100 || got_q[1] !== 4'b0000) begin
            bad++;
            $display("FAIL rst_newdata: got %0d pairs first %b want 1100 0000", got_q.size(), (got_q.size() > 0) ? got_q[0] : 4'bx);
        end
    endtask

    task automatic test_random();
        bit to;
        int errs;
        int len;
        bit [1:0] r;
        for (int round = 0; round < 4; round++) begin
            r   = 2'(round == 0 ? 0 : $urandom_range(0, 3));
            len = (round == 0) ? 900 : 300;
            tick(1'b1, r, 1'b0, 2'd0, 1'b1);
            for (int i = 0; i < len; i++)
                tick(1'b0, 2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
                     2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
            drain(1200, to);
            total++;
            if (got_q.size() != exp_q.size() || to) begin
                bad++;
                $display("FAIL rnd%0d_count: rate %0d got %0d pairs want %0d", round, r, got_q.size(), exp_q.size());
            end
            errs = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                if (got_q[i] !== exp_q[i]) errs++;
            total++;
            if (errs != 0) begin
                bad++;
                $display("FAIL rnd%0d_data: rate %0d, %0d pairs differ, want 0", round, r, errs);
            end
            total++;
            if (overflow !== 1'b0) begin
                bad++;
                $display("FAIL rnd%0d_ovf: got %b want 0", round, overflow);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rate12();
        test_rate23();
        test_rate34();
        test_backpressure();
        test_overflow();
        test_start_mid();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
